// File: rtl/fetch_stage.sv
// fetch_stage: PC, redirect/halt control and IF/ID register for the 5-stage MIPS core
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic        haltD,
  input  logic [31:0] pcbranchD,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_n;
  logic [31:0] pc_f, pc_n, pcplus4_f, jump_target, instr_n, pcplus4_n, count_n;
  logic valid_n, eff, eff_halt, eff_jump, eff_branch;
  assign imem_addr = pc_f;
  assign pcplus4_f = pc_f + 32'd4;
  assign jump_target = {pcplus4D[31:28], instrD[25:0], 2'b00};
  assign eff = validD & ~stallD;
  assign eff_halt = eff & haltD;
  assign eff_jump = eff & jumpD;
  assign eff_branch = eff & pcsrcD;
  assign halted = state == HALTED;
  always_comb begin
    state_n = state;
    pc_n = pc_f;
    instr_n = instrD;
    pcplus4_n = pcplus4D;
    valid_n = validD;
    count_n = fetch_count;
    if (state == RUN) begin
      if (eff_halt | eff_jump | eff_branch) begin
        instr_n = NOP_INSTR;
        pcplus4_n = '0;
        valid_n = 1'b0;
      end
      if (eff_halt)
        state_n = HALTED;
      else if (eff_jump | eff_branch)
        pc_n = eff_jump ? jump_target : pcbranchD;
      else begin
        pc_n = stallF ? pc_f : pcplus4_f;
        if (!stallD) begin
          instr_n = imem_rdata;
          pcplus4_n = pcplus4_f;
          valid_n = 1'b1;
          count_n = fetch_count + 32'd1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc_f <= RESET_PC;
      instrD <= NOP_INSTR;
      pcplus4D <= '0;
      validD <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc_f <= pc_n;
      instrD <= instr_n;
      pcplus4D <= pcplus4_n;
      validD <= valid_n;
      fetch_count <= count_n;
    end
  end
endmodule
